conv_window_sequencer: RTL and testbench

Synchronous control FSM that drives the single-PE 3x3 convolution datapath over a 4x4 input, producing a 2x2 output. It issues tap and window selects to the operand muxes, enables and clears the PE accumulator, and writes each finished window result to the output register bank. It replaces free-running counter decode with a start/busy/done handshake, so the convolution can be re-run without a global reset.

---
 rtl/conv_seq_pkg.sv | 22 ++
 rtl/mod_n_counter.sv | 40 ++++
 rtl/conv_window_sequencer.sv | 128 ++++++++++++
 tb/tb_conv_window_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared constants and state encoding for the 3x3 convolution window sequencer.
package conv_seq_pkg;

    localparam int unsigned TAPS    = 9;
    localparam int unsigned WINDOWS = 4;
    localparam int unsigned TAP_W   = 4;
    localparam int unsigned WIN_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MAC     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Output bank addresses: row/column of the 2x2 result.
    localparam logic [WIN_W-1:0] O00 = 2'd0;
    localparam logic [WIN_W-1:0] O01 = 2'd1;
    localparam logic [WIN_W-1:0] O10 = 2'd2;
    localparam logic [WIN_W-1:0] O11 = 2'd3;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-(TERM+1) up-counter with synchronous clear, enable and terminal-count flag.
// Wraps to zero only when enabled at the terminal count.
module mod_n_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned TERM  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc_o    = (count_q == WIDTH'(TERM));
    assign count_o = count_q;

    // Next count: clear wins over enable; wrap at the terminal count.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Start/busy/done control FSM for the single-PE 3x3 convolution over a 4x4 input.
// Steps 9 MAC taps per window over 4 windows, writing each result to the output bank.
// Optional feature: define CONV_SEQ_ABORT_EN to add an 'abort' input that cancels a run.
module conv_window_sequencer #(
    parameter int unsigned TAPS    = conv_seq_pkg::TAPS,
    parameter int unsigned WINDOWS = conv_seq_pkg::WINDOWS
) (
    input  logic                             clk_in,
    input  logic                             rst,
    input  logic                             start,
`ifdef CONV_SEQ_ABORT_EN
    input  logic                             abort,
`endif
    output logic                             busy,
    output logic                             done,
    output logic [conv_seq_pkg::TAP_W-1:0]   tap_sel,
    output logic [conv_seq_pkg::WIN_W-1:0]   win_sel,
    output logic                             pe_en,
    output logic                             pe_clear,
    output logic                             out_we,
    output logic [conv_seq_pkg::WIN_W-1:0]   out_idx
);

    import conv_seq_pkg::*;

    state_e             state_q;
    state_e             state_d;
    logic [TAP_W-1:0]   tap_q;
    logic [WIN_W-1:0]   win_q;
    logic               tap_tc;
    logic               win_tc;
    logic               abort_act;

    // Abort only acts while a run is in flight.
`ifdef CONV_SEQ_ABORT_EN
    assign abort_act = abort && ((state_q == MAC) || (state_q == CAPTURE));
`else
    assign abort_act = 1'b0;
`endif

    // Tap counter: advances every MAC cycle, held at zero elsewhere.
    mod_n_counter #(
        .WIDTH (TAP_W),
        .TERM  (TAPS - 1)
    ) u_tap_cnt (
        .clk_i   (clk_in),
        .rst_i   (rst),
        .clr_i   ((state_q != MAC) || abort_act),
        .en_i    (state_q == MAC),
        .count_o (tap_q),
        .tc_o    (tap_tc)
    );

    // Window counter: advances on each capture, cleared between runs.
    mod_n_counter #(
        .WIDTH (WIN_W),
        .TERM  (WINDOWS - 1)
    ) u_win_cnt (
        .clk_i   (clk_in),
        .rst_i   (rst),
        .clr_i   ((state_q == IDLE) || (state_q == DONE) || abort_act),
        .en_i    (state_q == CAPTURE),
        .count_o (win_q),
        .tc_o    (win_tc)
    );

    // State register with synchronous active-high reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode from state and counters.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        tap_sel  = '0;
        win_sel  = '0;
        pe_en    = 1'b0;
        pe_clear = 1'b0;
        out_we   = 1'b0;
        out_idx  = '0;
        unique case (state_q)
            IDLE: begin
                pe_clear = 1'b1;
                if (start) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                busy    = 1'b1;
                pe_en   = 1'b1;
                tap_sel = tap_q;
                win_sel = win_q;
                if (abort_act) begin
                    state_d = IDLE;
                end else if (tap_tc) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                busy     = 1'b1;
                win_sel  = win_q;
                pe_clear = 1'b1;
                out_idx  = win_q;
                if (abort_act) begin
                    state_d = IDLE;
                end else begin
                    out_we  = 1'b1;
                    state_d = win_tc ? DONE : MAC;
                end
            end
            DONE: begin
                done     = 1'b1;
                pe_clear = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed self-checking bench for conv_window_sequencer, with a small PE/output-bank model.
module tb_conv_window_sequencer;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       start  = 1'b0;
`ifdef CONV_SEQ_ABORT_EN
    logic       abort  = 1'b0;
`endif
    logic       busy;
    logic       done;
    logic [3:0] tap_sel;
    logic [1:0] win_sel;
    logic       pe_en;
    logic       pe_clear;
    logic       out_we;
    logic [1:0] out_idx;

    int n_vec = 0;
    int n_err = 0;

    // Observed control word: {busy, done, tap_sel, win_sel, pe_en, pe_clear, out_we, out_idx}
    logic [13:0] obs;
    assign obs = {busy, done, tap_sel, win_sel, pe_en, pe_clear, out_we, out_idx};

    conv_window_sequencer dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (start),
`ifdef CONV_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .tap_sel  (tap_sel),
        .win_sel  (win_sel),
        .pe_en    (pe_en),
        .pe_clear (pe_clear),
        .out_we   (out_we),
        .out_idx  (out_idx)
    );

    always #5 clk_in = ~clk_in;

    // PE and output bank model: all pixels and all filter taps equal 1.
    localparam logic [7:0] PIX  = 8'd1;
    localparam logic [7:0] COEF = 8'd1;
    logic [7:0] acc = 8'd0;
    logic [7:0] bank [4] = '{default: 8'hFF};

    always @(posedge clk_in) begin
        if (pe_clear) acc <= 8'd0;
        else if (pe_en) acc <= acc + 8'(PIX * COEF);
        if (out_we) bank[out_idx] <= acc;
    end

    // Expected control word for run cycle p (0 = IDLE, 1..40 busy, 41 = DONE, 42 = IDLE).
    function automatic logic [13:0] exp_vec(input int p);
        logic       b, d, en, clr, we;
        logic [3:0] t;
        logic [1:0] w, ix;
        b = 1'b0; d = 1'b0; en = 1'b0; clr = 1'b0; we = 1'b0;
        t = 4'd0; w = 2'd0; ix = 2'd0;
        if (p >= 1 && p <= 40) begin
            b = 1'b1;
            w = 2'((p - 1) / 10);
            if ((p - 1) % 10 < 9) begin
                en = 1'b1;
                t  = 4'((p - 1) % 10);
            end else begin
                clr = 1'b1;
                we  = 1'b1;
                ix  = w;
            end
        end else if (p == 41) begin
            d   = 1'b1;
            clr = 1'b1;
        end else begin
            clr = 1'b1;
        end
        return {b, d, t, w, en, clr, we, ix};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk_in);
        n_vec++;
        if (obs !== exp_vec(0)) begin
            n_err++;
            $display("FAIL reset_hold: got %b want %b", obs, exp_vec(0));
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            n_vec++;
            if (obs !== exp_vec(0)) begin
                n_err++;
                $display("FAIL reset_idle cycle %0d: got %b want %b", i, obs, exp_vec(0));
            end
        end
    endtask

    task automatic test_single_run();
        @(negedge clk_in);
        start = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk_in);
            start = 1'b0;
            n_vec++;
            if (obs !== exp_vec(c)) begin
                n_err++;
                $display("FAIL single_run cycle %0d: got %b want %b", c, obs, exp_vec(c));
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (bank[i] !== 8'd9) begin
                n_err++;
                $display("FAIL bank_value idx %0d: got %0d want 9", i, bank[i]);
            end
        end
    endtask

    task automatic test_sequencing();
        logic [3:0] et;
        logic [1:0] ew;
        logic       ee;
        @(negedge clk_in);
        start = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk_in);
            start = 1'b0;
            if (c <= 20) begin
                et = (c <= 9) ? 4'(c - 1) : ((c >= 11 && c <= 19) ? 4'(c - 11) : 4'd0);
                ew = (c <= 10) ? 2'd0 : 2'd1;
                ee = (c != 10) && (c != 20);
                n_vec++;
                if (tap_sel !== et || win_sel !== ew || pe_en !== ee) begin
                    n_err++;
                    $display("FAIL sequencing cycle %0d: got tap %0d win %0d en %b want tap %0d win %0d en %b",
                             c, tap_sel, win_sel, pe_en, et, ew, ee);
                end
            end
        end
    endtask

    task automatic test_ignored_start();
        @(negedge clk_in);
        start = 1'b1;
        for (int c = 1; c <= 43; c++) begin
            @(negedge clk_in);
            start = 1'b0;
            n_vec++;
            if (obs !== exp_vec(c > 42 ? 0 : c)) begin
                n_err++;
                $display("FAIL ignored_start cycle %0d: got %b want %b", c, obs, exp_vec(c > 42 ? 0 : c));
            end
            if (c == 5 || c == 10 || c == 20 || c == 41) start = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_in);
        start = 1'b1;
        for (int c = 1; c <= 126; c++) begin
            @(negedge clk_in);
            n_vec++;
            if (obs !== exp_vec(c % 42)) begin
                n_err++;
                $display("FAIL back_to_back cycle %0d: got %b want %b", c, obs, exp_vec(c % 42));
            end
        end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk_in);
        rst   = 1'b0;
    endtask

    task automatic test_reset_midrun();
        @(negedge clk_in);
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk_in);
            start = 1'b0;
            n_vec++;
            if (obs !== exp_vec(c)) begin
                n_err++;
                $display("FAIL midrun_pre cycle %0d: got %b want %b", c, obs, exp_vec(c));
            end
        end
        rst = 1'b1;
        @(negedge clk_in);
        n_vec++;
        if (obs !== exp_vec(0)) begin
            n_err++;
            $display("FAIL midrun_reset: got %b want %b", obs, exp_vec(0));
        end
        rst   = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk_in);
            start = 1'b0;
            n_vec++;
            if (obs !== exp_vec(c)) begin
                n_err++;
                $display("FAIL midrun_rerun cycle %0d: got %b want %b", c, obs, exp_vec(c));
            end
        end
        n_vec++;
        if (bank[0] !== 8'd9) begin
            n_err++;
            $display("FAIL midrun_bank0: got %0d want 9", bank[0]);
        end
    endtask

`ifdef CONV_SEQ_ABORT_EN
    task automatic test_abort();
        @(negedge clk_in);
        start = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk_in);
            start = 1'b0;
            n_vec++;
            if (obs !== exp_vec(c)) begin
                n_err++;
                $display("FAIL abort_pre cycle %0d: got %b want %b", c, obs, exp_vec(c));
            end
        end
        @(negedge clk_in);
        abort = 1'b1;
        #1;
        n_vec++;
        if (out_we !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_capture: got we %b done %b want we 0 done 0", out_we, done);
        end
        @(negedge clk_in);
        abort = 1'b0;
        for (int c = 21; c <= 45; c++) begin
            n_vec++;
            if (obs !== exp_vec(0)) begin
                n_err++;
                $display("FAIL abort_idle cycle %0d: got %b want %b", c, obs, exp_vec(0));
            end
            @(negedge clk_in);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_run();
        test_sequencing();
        test_ignored_start();
        test_back_to_back();
        test_reset_midrun();
`ifdef CONV_SEQ_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
